// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-back, write-allocate data cache with true-LRU and flush
module dcache_assoc #(
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dcache_command,
  input  logic [31:0] proc2Dcache_addr,
  input  logic [63:0] proc2Dcache_data,
  input  logic [2:0]  mem_size,
  input  logic        flush_req,
  input  logic [3:0]  Dmem2proc_response,
  input  logic [63:0] Dmem2proc_data,
  input  logic [3:0]  Dmem2proc_tag,
  output logic [1:0]  proc2Dmem_command,
  output logic [31:0] proc2Dmem_addr,
  output logic [63:0] proc2Dmem_data,
  output logic [63:0] Dcache_data_out,
  output logic        Dcache_valid_out,
  output logic        finished,
  output logic        flush_done
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL_REQ, S_FILL_WAIT, S_FLUSH, S_FLUSH_DONE
  } state_t;

  typedef logic [SETS-1:0][WAYS-1:0][AW-1:0] age_arr_t;

  function automatic age_arr_t age_init();
    age_arr_t r;
    r = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        r[s][w] = AW'(w);
    return r;
  endfunction

  state_t state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  age_arr_t                  age_q;
  logic [TW-1:0]             tag_q  [SETS][WAYS];
  logic [63:0]               data_q [SETS][WAYS];

  logic [3:0]    fill_tag_q;
  logic [IW-1:0] miss_index_q;
  logic [TW-1:0] miss_tag_q;
  logic [AW-1:0] victim_q;
  logic [IW-1:0] flush_set_q;
  logic [AW-1:0] flush_way_q;

  logic [IW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic          is_load, is_store;

  assign req_index = proc2Dcache_addr[3+IW-1:3];
  assign req_tag   = proc2Dcache_addr[31:3+IW];
  assign is_load   = (proc2Dcache_command == 2'd1);
  assign is_store  = (proc2Dcache_command == 2'd2);

  logic          hit;
  logic [AW-1:0] hit_way, victim_way;

  // Descending scans leave the lowest-numbered matching way in place.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
    for (int w = 0; w < WAYS; w++)
      if (age_q[req_index][w] == AW'(WAYS - 1)) victim_way = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_index][w]) victim_way = AW'(w);
  end

  logic [2:0]  offset;
  logic [7:0]  size_mask, byte_en;
  logic [63:0] hit_line, line_shift, load_ext, store_shift, bit_mask, store_merged;

  always_comb begin
    offset       = 3'd0;
    size_mask    = 8'hff;
    hit_line     = data_q[req_index][hit_way];
    line_shift   = '0;
    load_ext     = '0;
    store_shift  = '0;
    byte_en      = '0;
    bit_mask     = '0;
    store_merged = '0;
    case (mem_size[1:0])
      2'd0:    begin offset = proc2Dcache_addr[2:0];          size_mask = 8'h01; end
      2'd1:    begin offset = {proc2Dcache_addr[2:1], 1'b0};  size_mask = 8'h03; end
      2'd2:    begin offset = {proc2Dcache_addr[2], 2'b00};   size_mask = 8'h0f; end
      default: begin offset = 3'd0;                           size_mask = 8'hff; end
    endcase
    line_shift = hit_line >> {offset, 3'b000};
    case (mem_size[1:0])
      2'd0: load_ext = mem_size[2] ? {56'd0, line_shift[7:0]}
                                   : {{56{line_shift[7]}}, line_shift[7:0]};
      2'd1: load_ext = mem_size[2] ? {48'd0, line_shift[15:0]}
                                   : {{48{line_shift[15]}}, line_shift[15:0]};
      2'd2: load_ext = mem_size[2] ? {32'd0, line_shift[31:0]}
                                   : {{32{line_shift[31]}}, line_shift[31:0]};
      default: load_ext = line_shift;
    endcase
    store_shift = proc2Dcache_data << {offset, 3'b000};
    byte_en     = size_mask << offset;
    for (int b = 0; b < 8; b++)
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    store_merged = (hit_line & ~bit_mask) | (store_shift & bit_mask);
  end

  logic flush_dirty, flush_last;
  assign flush_dirty = dirty_q[flush_set_q][flush_way_q];
  assign flush_last  = (flush_set_q == IW'(SETS - 1)) && (flush_way_q == AW'(WAYS - 1));

  logic          store_en, fill_en, age_en, miss_start, fill_accept;
  logic          flush_start, flush_adv, flush_clean;
  logic [IW-1:0] age_set;
  logic [AW-1:0] age_way, old_age;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    proc2Dmem_command = 2'd0;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    Dcache_data_out   = '0;
    Dcache_valid_out  = 1'b0;
    finished          = 1'b0;
    flush_done        = 1'b0;
    store_en          = 1'b0;
    fill_en           = 1'b0;
    age_en            = 1'b0;
    miss_start        = 1'b0;
    fill_accept       = 1'b0;
    flush_start       = 1'b0;
    flush_adv         = 1'b0;
    flush_clean       = 1'b0;
    age_set           = req_index;
    age_way           = hit_way;
    case (state_q)
      S_IDLE: begin
        if (is_load || is_store) begin
          if (hit) begin
            finished = 1'b1;
            age_en   = 1'b1;
            if (is_load) begin
              Dcache_valid_out = 1'b1;
              Dcache_data_out  = load_ext;
            end else begin
              store_en = 1'b1;
            end
          end else begin
            miss_start = 1'b1;
            state_d = (valid_q[req_index][victim_way] && dirty_q[req_index][victim_way])
                      ? S_WB : S_FILL_REQ;
          end
        end else if (flush_req) begin
          flush_start = 1'b1;
          state_d     = S_FLUSH;
        end
      end
      S_WB: begin
        proc2Dmem_command = 2'd2;
        proc2Dmem_addr    = {tag_q[miss_index_q][victim_q], miss_index_q, 3'b000};
        proc2Dmem_data    = data_q[miss_index_q][victim_q];
        if (Dmem2proc_response != 4'd0) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        proc2Dmem_command = 2'd1;
        proc2Dmem_addr    = {miss_tag_q, miss_index_q, 3'b000};
        if (Dmem2proc_response != 4'd0) begin
          fill_accept = 1'b1;
          state_d     = S_FILL_WAIT;
        end
      end
      S_FILL_WAIT: begin
        if ((Dmem2proc_tag != 4'd0) && (Dmem2proc_tag == fill_tag_q)) begin
          fill_en = 1'b1;
          age_en  = 1'b1;
          age_set = miss_index_q;
          age_way = victim_q;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_dirty) begin
          proc2Dmem_command = 2'd2;
          proc2Dmem_addr    = {tag_q[flush_set_q][flush_way_q], flush_set_q, 3'b000};
          proc2Dmem_data    = data_q[flush_set_q][flush_way_q];
          if (Dmem2proc_response != 4'd0) begin
            flush_clean = 1'b1;
            flush_adv   = 1'b1;
          end
        end else begin
          flush_adv = 1'b1;
        end
        if (flush_adv && flush_last) state_d = S_FLUSH_DONE;
      end
      S_FLUSH_DONE: begin
        flush_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_tag_q   <= '0;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      victim_q     <= '0;
      flush_set_q  <= '0;
      flush_way_q  <= '0;
    end else begin
      if (miss_start) begin
        miss_index_q <= req_index;
        miss_tag_q   <= req_tag;
        victim_q     <= victim_way;
      end
      if (fill_accept) fill_tag_q <= Dmem2proc_response;
      if (flush_start) begin
        flush_set_q <= '0;
        flush_way_q <= '0;
      end else if (flush_adv && !flush_last) begin
        if (flush_way_q == AW'(WAYS - 1)) begin
          flush_way_q <= '0;
          flush_set_q <= flush_set_q + IW'(1);
        end else begin
          flush_way_q <= flush_way_q + AW'(1);
        end
      end
    end
  end

  assign old_age = age_q[age_set][age_way];

  // Touched way becomes MRU; only ways younger than it age by one.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      age_q   <= age_init();
    end else begin
      if (store_en) dirty_q[req_index][hit_way] <= 1'b1;
      if (fill_en) begin
        valid_q[miss_index_q][victim_q] <= 1'b1;
        dirty_q[miss_index_q][victim_q] <= 1'b0;
      end
      if (flush_clean) dirty_q[flush_set_q][flush_way_q] <= 1'b0;
      if (age_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == age_way)
            age_q[age_set][w] <= '0;
          else if (age_q[age_set][w] < old_age)
            age_q[age_set][w] <= age_q[age_set][w] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (store_en) data_q[req_index][hit_way] <= store_merged;
      if (fill_en) begin
        data_q[miss_index_q][victim_q] <= Dmem2proc_data;
        tag_q[miss_index_q][victim_q]  <= miss_tag_q;
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// tb/tb_dcache_assoc.sv - directed self-checking bench for dcache_assoc
module tb_dcache_assoc;
  logic        clock, reset;
  logic [1:0]  proc2Dcache_command;
  logic [31:0] proc2Dcache_addr;
  logic [63:0] proc2Dcache_data;
  logic [2:0]  mem_size;
  logic        flush_req;
  logic [3:0]  Dmem2proc_response;
  logic [63:0] Dmem2proc_data;
  logic [3:0]  Dmem2proc_tag;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [63:0] proc2Dmem_data;
  logic [63:0] Dcache_data_out;
  logic        Dcache_valid_out;
  logic        finished;
  logic        flush_done;

  dcache_assoc #(.SETS(16), .WAYS(2)) dut (
    .clock(clock), .reset(reset),
    .proc2Dcache_command(proc2Dcache_command), .proc2Dcache_addr(proc2Dcache_addr),
    .proc2Dcache_data(proc2Dcache_data), .mem_size(mem_size), .flush_req(flush_req),
    .Dmem2proc_response(Dmem2proc_response), .Dmem2proc_data(Dmem2proc_data),
    .Dmem2proc_tag(Dmem2proc_tag), .proc2Dmem_command(proc2Dmem_command),
    .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
    .Dcache_data_out(Dcache_data_out), .Dcache_valid_out(Dcache_valid_out),
    .finished(finished), .flush_done(flush_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: accepts any request at once, returns load data three cycles later.
  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
  } req_t;

  req_t        log_q[$];
  logic [63:0] mem [int unsigned];
  int          pend_cnt;
  logic [3:0]  pend_tag, next_tag;
  logic [63:0] pend_data;

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a};
  endfunction

  initial begin
    Dmem2proc_response = 4'd0;
    Dmem2proc_tag      = 4'd0;
    Dmem2proc_data     = 64'd0;
    pend_cnt  = 0;
    pend_tag  = 4'd0;
    pend_data = 64'd0;
    next_tag  = 4'd1;
    forever begin
      @(negedge clock);
      Dmem2proc_response = 4'd0;
      Dmem2proc_tag      = 4'd0;
      Dmem2proc_data     = 64'd0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          Dmem2proc_tag  = pend_tag;
          Dmem2proc_data = pend_data;
        end
      end
      if (proc2Dmem_command != 2'd0) begin
        Dmem2proc_response = next_tag;
        log_q.push_back('{proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data});
        if (proc2Dmem_command == 2'd2) begin
          mem[proc2Dmem_addr] = proc2Dmem_data;
        end else begin
          pend_cnt  = 3;
          pend_tag  = next_tag;
          pend_data = mem_rd(proc2Dmem_addr);
        end
        next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      end
    end
  end

  task automatic access(input logic [1:0] cmd, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, output logic [63:0] rdata, output logic vout,
                        output int cycles);
    logic done, leak;
    @(negedge clock);
    proc2Dcache_command = cmd;
    proc2Dcache_addr    = addr;
    mem_size            = size;
    proc2Dcache_data    = wdata;
    done = 1'b0; leak = 1'b0; cycles = 0; rdata = '0; vout = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (finished) begin
        done  = 1'b1;
        rdata = Dcache_data_out;
        vout  = Dcache_valid_out;
        break;
      end
      if (Dcache_valid_out) leak = 1'b1;
      cycles++;
      @(negedge clock);
    end
    check("finished", done, 1'b1);
    check("valid_while_missing", leak, 1'b0);
    @(negedge clock);
    proc2Dcache_command = 2'd0;
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [63:0] exp, input logic exp_hit);
    logic [63:0] r; logic v; int c;
    access(2'd1, addr, size, 64'd0, r, v, c);
    check({tag, ".data"}, r, exp);
    check({tag, ".valid"}, v, 1'b1);
    check({tag, ".hit"}, (c == 0), exp_hit);
  endtask

  task automatic st(input string tag, input logic [31:0] addr, input logic [2:0] size,
                    input logic [63:0] data, input logic exp_hit);
    logic [63:0] r; logic v; int c;
    access(2'd2, addr, size, data, r, v, c);
    check({tag, ".valid"}, v, 1'b0);
    check({tag, ".hit"}, (c == 0), exp_hit);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [1:0] cmd,
                         input logic [31:0] addr, input logic [63:0] data);
    if (idx < log_q.size()) begin
      check({tag, ".cmd"}, log_q[idx].cmd, cmd);
      check({tag, ".addr"}, log_q[idx].addr, addr);
      if (cmd == 2'd2) check({tag, ".wdata"}, log_q[idx].data, data);
    end else begin
      check({tag, ".present"}, 1'b0, 1'b1);
    end
  endtask

  task automatic do_flush(input logic hold_cmd, output int pulses, output int busy_fin);
    log_q.delete();
    pulses = 0; busy_fin = 0;
    @(negedge clock);
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    if (hold_cmd) begin
      proc2Dcache_command = 2'd1;
      proc2Dcache_addr    = 32'h010;
      mem_size            = 3'd3;
    end
    for (int i = 0; i < 80; i++) begin
      #1;
      if (flush_done) pulses++;
      else if (pulses == 0 && finished) busy_fin++;
      @(negedge clock);
    end
    proc2Dcache_command = 2'd0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, ".mem_cmd"}, proc2Dmem_command, 2'd0);
    check({tag, ".mem_addr"}, proc2Dmem_addr, 32'd0);
    check({tag, ".mem_data"}, proc2Dmem_data, 64'd0);
    check({tag, ".data_out"}, Dcache_data_out, 64'd0);
    check({tag, ".valid_out"}, Dcache_valid_out, 1'b0);
    check({tag, ".finished"}, finished, 1'b0);
    check({tag, ".flush_done"}, flush_done, 1'b0);
  endtask

  localparam logic [63:0] D1 = 64'hFFFF_1234_4321_FFFF;
  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D4 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D5 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] L20 = 64'h0000_0020_80FF_FFDF;

  initial begin
    int pulses, busy, got;
    reset = 1'b1;
    proc2Dcache_command = 2'd0;
    proc2Dcache_addr    = 32'd0;
    proc2Dcache_data    = 64'd0;
    mem_size            = 3'd0;
    flush_req           = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    log_q.delete();
    st("cold_st", 32'h010, 3'd3, D1, 1'b0);
    check("cold_st.nreq", log_q.size(), 1);
    chk_log("cold_st.req", 0, 2'd1, 32'h010, 64'd0);
    ld("cold_ld", 32'h010, 3'd3, D1, 1'b1);

    log_q.delete();
    st("st090", 32'h090, 3'd3, D2, 1'b0);
    check("st090.nreq", log_q.size(), 1);
    chk_log("st090.req", 0, 2'd1, 32'h090, 64'd0);
    log_q.delete();
    st("st110", 32'h110, 3'd3, D3, 1'b0);
    check("st110.nreq", log_q.size(), 2);
    chk_log("st110.wb", 0, 2'd2, 32'h010, D1);
    chk_log("st110.fill", 1, 2'd1, 32'h110, 64'd0);
    ld("keep090", 32'h090, 3'd3, D2, 1'b1);
    ld("hit110", 32'h110, 3'd3, D3, 1'b1);

    log_q.delete();
    ld("lru_a", 32'h010, 3'd3, D1, 1'b0);
    check("lru_a.nreq", log_q.size(), 2);
    chk_log("lru_a.wb", 0, 2'd2, 32'h090, D2);
    chk_log("lru_a.fill", 1, 2'd1, 32'h010, 64'd0);
    log_q.delete();
    ld("lru_b", 32'h090, 3'd3, D2, 1'b0);
    check("lru_b.nreq", log_q.size(), 2);
    chk_log("lru_b.wb", 0, 2'd2, 32'h110, D3);
    chk_log("lru_b.fill", 1, 2'd1, 32'h090, 64'd0);
    ld("lru_c", 32'h010, 3'd3, D1, 1'b1);
    log_q.delete();
    ld("lru_d", 32'h110, 3'd3, D3, 1'b0);
    check("lru_d.nreq", log_q.size(), 1);
    chk_log("lru_d.fill", 0, 2'd1, 32'h110, 64'd0);
    ld("lru_e", 32'h010, 3'd3, D1, 1'b1);

    log_q.delete();
    st("st_byte", 32'h023, 3'd0, 64'h80, 1'b0);
    chk_log("st_byte.fill", 0, 2'd1, 32'h020, 64'd0);
    ld("ext_sb", 32'h023, 3'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
    ld("ext_ub", 32'h023, 3'd4, 64'h0000_0000_0000_0080, 1'b1);
    ld("ext_sh", 32'h022, 3'd1, 64'hFFFF_FFFF_FFFF_80FF, 1'b1);
    ld("ext_uw", 32'h020, 3'd6, 64'h0000_0000_80FF_FFDF, 1'b1);
    ld("ext_sw", 32'h025, 3'd2, 64'h0000_0000_0000_0020, 1'b1);
    ld("ext_d", 32'h027, 3'd3, L20, 1'b1);

    st("st018", 32'h018, 3'd3, D4, 1'b0);
    st("st110b", 32'h110, 3'd3, D5, 1'b1);
    do_flush(1'b0, pulses, busy);
    check("flush1.pulses", pulses, 1);
    check("flush1.nstores", log_q.size(), 3);
    chk_log("flush1.s0", 0, 2'd2, 32'h110, D5);
    chk_log("flush1.s1", 1, 2'd2, 32'h018, D4);
    chk_log("flush1.s2", 2, 2'd2, 32'h020, L20);
    do_flush(1'b1, pulses, busy);
    check("flush2.pulses", pulses, 1);
    check("flush2.nstores", log_q.size(), 0);
    check("flush2.cmd_ignored", busy, 0);
    ld("post_flush", 32'h018, 3'd3, D4, 1'b1);

    log_q.delete();
    @(negedge clock);
    proc2Dcache_command = 2'd1;
    proc2Dcache_addr    = 32'h050;
    mem_size            = 3'd3;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (log_q.size() > 0) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    check("rst.fill_req_seen", got, 1);
    @(negedge clock);
    reset = 1'b1;
    proc2Dcache_command = 2'd0;
    @(posedge clock);
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    chk_idle_outputs("rst_stale");
    log_q.delete();
    ld("rst_ld010", 32'h010, 3'd3, D1, 1'b0);
    chk_log("rst_ld010.fill", 0, 2'd1, 32'h010, 64'd0);
    ld("rst_ld050", 32'h050, 3'd3, 64'h0000_0050_FFFF_FFAF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
